// File: rtl/dram_rsp_pkg.sv
// -----------------------------------------------------------------------------
// dram_rsp_pkg
// Shared configuration and types for the external-memory responder.
//   DATA_WIDTH / ADDR_WIDTH : word and word-address widths
//   RD_LATENCY              : read request to valid, in cycles (>= 1)
//   WB_DEPTH                : write-buffer entries (power of 2)
//   wb_entry_t              : one buffered write {addr, data}
// Optional feature macro used by the files that import this package:
//   DRAM_RSP_WB_FWD_EN      : read forwarding from the write buffer
// -----------------------------------------------------------------------------
package dram_rsp_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 18;
  localparam int RD_LATENCY = 2;
  localparam int WB_DEPTH   = 4;

  // Legality of the configuration, kept as constants next to the values.
  localparam bit RD_LATENCY_OK = (RD_LATENCY >= 1);
  localparam bit WB_DEPTH_OK   = (WB_DEPTH >= 1) && ((WB_DEPTH & (WB_DEPTH - 1)) == 0);

  // Pointer width stays at least 1 so a single-entry buffer still elaborates.
  localparam int WB_PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int WB_CNT_W = $clog2(WB_DEPTH + 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/dram_wbuf.sv
// -----------------------------------------------------------------------------
// dram_wbuf
// FIFO write buffer in front of the single-port array.
//   clk        : clock, rising edge
//   i_srstn    : synchronous active-low reset (pointers and count only)
//   i_push     : enqueue i_entry at the tail (ignored when full with no pop)
//   i_entry    : write to enqueue
//   i_pop      : dequeue the head entry (ignored when empty)
//   o_head     : current head entry
//   o_count    : number of pending entries, 0..WB_DEPTH
//   o_full     : count == WB_DEPTH
// With DRAM_RSP_WB_FWD_EN defined, a combinational lookup port is added:
//   i_lk_addr  : address to search for
//   o_lk_hit   : some pending entry matches
//   o_lk_data  : data of the newest matching entry
// -----------------------------------------------------------------------------
module dram_wbuf
  import dram_rsp_pkg::*;
(
  input  logic                clk,
  input  logic                i_srstn,
  input  logic                i_push,
  input  wb_entry_t           i_entry,
  input  logic                i_pop,
  output wb_entry_t           o_head,
  output logic [WB_CNT_W-1:0] o_count,
  output logic                o_full
`ifdef DRAM_RSP_WB_FWD_EN
  ,
  input  logic [ADDR_WIDTH-1:0] i_lk_addr,
  output logic                  o_lk_hit,
  output logic [DATA_WIDTH-1:0] o_lk_data
`endif
);

  wb_entry_t             r_mem [WB_DEPTH];
  logic [WB_PTR_W-1:0]   r_wr_ptr;
  logic [WB_PTR_W-1:0]   r_rd_ptr;
  logic [WB_CNT_W-1:0]   r_count;
  logic                  w_pop;
  logic                  w_push;

  function automatic logic [WB_PTR_W-1:0] ptr_inc(input logic [WB_PTR_W-1:0] p);
    return (int'(p) == WB_DEPTH - 1) ? '0 : p + WB_PTR_W'(1);
  endfunction

  assign o_full  = (r_count == WB_CNT_W'(WB_DEPTH));
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && (!o_full || w_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!i_srstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + WB_CNT_W'(1);
        2'b01:   r_count <= r_count - WB_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is not reset; only the pointers and count decide which
  // entries are live, so clearing the data would just cost reset fan-out.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_entry;
  end

`ifdef DRAM_RSP_WB_FWD_EN
  // Walk from oldest to newest so a later match overrides an earlier one.
  // NOTE: outputs get defaults before the loop, so no path leaves them
  // unassigned and no latch is inferred.
  always_comb begin
    o_lk_hit  = 1'b0;
    o_lk_data = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (i < int'(r_count) &&
          r_mem[WB_PTR_W'((int'(r_rd_ptr) + i) % WB_DEPTH)].addr == i_lk_addr) begin
        o_lk_hit  = 1'b1;
        o_lk_data = r_mem[WB_PTR_W'((int'(r_rd_ptr) + i) % WB_DEPTH)].data;
      end
    end
  end
`endif

endmodule

// File: rtl/dram_rsp.sv
// -----------------------------------------------------------------------------
// dram_rsp
// Memory-side responder for the accelerator's external-memory port. One read
// and one write per cycle; writes are queued in dram_wbuf and drained into a
// single-port array in cycles without a read. Array contents are not reset.
//   clk      : clock, rising edge
//   srstn    : synchronous active-low reset
//   en_wr    : write request       addr_wr : write address  data_in : write data
//   en_rd    : read request        addr_rd : read address
//   valid    : one-cycle pulse, RD_LATENCY cycles after each read
//   data_out : read data, holds its value while valid is low
//   wb_ovf   : sticky, a write was dropped on a full buffer
// Macro DRAM_RSP_WB_FWD_EN: reads forward from the same-cycle write and from
// pending buffer entries (newest first). Undefined: reads see the array only.
// -----------------------------------------------------------------------------
module dram_rsp
  import dram_rsp_pkg::*;
(
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  en_wr,
  input  logic [ADDR_WIDTH-1:0] addr_wr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  en_rd,
  input  logic [ADDR_WIDTH-1:0] addr_rd,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  wb_ovf
);

  logic [DATA_WIDTH-1:0] r_array [1 << ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] r_array_q;
  logic                  r_issue_v;
  logic [RD_LATENCY-1:0] r_pv;
  logic [DATA_WIDTH-1:0] r_pd [RD_LATENCY];
  logic                  r_ovf;

  logic                  w_rd;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_full;
  logic [WB_CNT_W-1:0]   w_count;
  wb_entry_t             w_head;
  logic [DATA_WIDTH-1:0] w_rd_data;

  // A read owns the array port; the buffer drains only in read-free cycles.
  assign w_rd   = srstn && en_rd;
  assign w_pop  = srstn && !en_rd && (w_count != '0);
  assign w_push = srstn && en_wr && (!w_full || w_pop);

`ifdef DRAM_RSP_WB_FWD_EN
  logic                  w_lk_hit;
  logic [DATA_WIDTH-1:0] w_lk_data;
  logic                  w_fwd_hit;
  logic [DATA_WIDTH-1:0] w_fwd_data;
  logic                  r_fwd_hit;
  logic [DATA_WIDTH-1:0] r_fwd_data;
`endif

  dram_wbuf u_wbuf (
    .clk       (clk),
    .i_srstn   (srstn),
    .i_push    (w_push),
    .i_entry   ('{addr: addr_wr, data: data_in}),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_count   (w_count),
    .o_full    (w_full)
`ifdef DRAM_RSP_WB_FWD_EN
    ,
    .i_lk_addr (addr_rd),
    .o_lk_hit  (w_lk_hit),
    .o_lk_data (w_lk_data)
`endif
  );

  always_ff @(posedge clk) begin
    if (w_pop)     r_array[w_head.addr] <= w_head.data;
    else if (w_rd) r_array_q <= r_array[addr_rd];
  end

`ifdef DRAM_RSP_WB_FWD_EN
  // The incoming write is newer than anything already buffered. A write that
  // is being dropped never forwards.
  always_comb begin
    w_fwd_hit  = w_lk_hit;
    w_fwd_data = w_lk_data;
    if (w_push && addr_wr == addr_rd) begin
      w_fwd_hit  = 1'b1;
      w_fwd_data = data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (w_rd) begin
      r_fwd_hit  <= w_fwd_hit;
      r_fwd_data <= w_fwd_data;
    end
  end

  assign w_rd_data = r_fwd_hit ? r_fwd_data : r_array_q;
`else
  assign w_rd_data = r_array_q;
`endif

  // r_issue_v marks the cycle the array/forward registers hold a result; the
  // RD_LATENCY stages behind it carry it to the outputs. Data stages load only
  // with a valid result so data_out holds between responses.
  always_ff @(posedge clk) begin
    if (!srstn) begin
      r_issue_v <= 1'b0;
      r_pv      <= '0;
      for (int i = 0; i < RD_LATENCY; i++) r_pd[i] <= '0;
    end else begin
      r_issue_v <= w_rd;
      r_pv[0]   <= r_issue_v;
      if (r_issue_v) r_pd[0] <= w_rd_data;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        if (r_pv[i-1]) r_pd[i] <= r_pd[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!srstn)                r_ovf <= 1'b0;
    else if (en_wr && !w_push) r_ovf <= 1'b1;
  end

  assign valid    = r_pv[RD_LATENCY-1];
  assign data_out = r_pd[RD_LATENCY-1];
  assign wb_ovf   = r_ovf;

endmodule

// File: tb/tb_dram_rsp.sv
// -----------------------------------------------------------------------------
// tb_dram_rsp
// Directed bench for dram_rsp. Inputs change just after the falling edge and
// outputs are sampled on the falling edge, half a cycle after the rising edge
// that produced them. Every valid response is appended to rsp_q in order.
// Expected values that depend on DRAM_RSP_WB_FWD_EN are selected with the
// same macro.
// -----------------------------------------------------------------------------
module tb_dram_rsp;
  import dram_rsp_pkg::*;

  logic                  clk = 1'b0;
  logic                  srstn;
  logic                  en_wr;
  logic [ADDR_WIDTH-1:0] addr_wr;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  en_rd;
  logic [ADDR_WIDTH-1:0] addr_rd;
  logic                  valid;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  wb_ovf;

  int checks = 0;
  int errors = 0;
  logic [DATA_WIDTH-1:0] rsp_q [$];

  dram_rsp dut (
    .clk      (clk),
    .srstn    (srstn),
    .en_wr    (en_wr),
    .addr_wr  (addr_wr),
    .data_in  (data_in),
    .en_rd    (en_rd),
    .addr_rd  (addr_rd),
    .valid    (valid),
    .data_out (data_out),
    .wb_ovf   (wb_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock of stimulus; records the response visible after that edge.
  task automatic step(input logic we, input logic [ADDR_WIDTH-1:0] aw,
                      input logic [DATA_WIDTH-1:0] wd, input logic re,
                      input logic [ADDR_WIDTH-1:0] ra);
    en_wr   = we;
    addr_wr = aw;
    data_in = wd;
    en_rd   = re;
    addr_rd = ra;
    @(negedge clk);
    if (valid === 1'b1) rsp_q.push_back(data_out);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, '0, 1'b0, '0);
  endtask

  // Write then one read-free cycle, which drains the (otherwise empty) buffer.
  task automatic preload(input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] d);
    step(1'b1, a, d, 1'b0, '0);
    idle(1);
  endtask

  task automatic test_reset();
    srstn = 1'b0;
    step(1'b1, 18'h30, 32'h0BAD_0BAD, 1'b1, 18'h30);
    step(1'b1, 18'h30, 32'h0BAD_0BAD, 1'b1, 18'h30);
    checks++; if (valid !== 1'b0)    begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (data_out !== '0)   begin errors++; $display("FAIL reset_data: got %h want 0", data_out); end
    checks++; if (wb_ovf !== 1'b0)   begin errors++; $display("FAIL reset_ovf: got %b want 0", wb_ovf); end
    srstn = 1'b1;
    idle(4);
    checks++; if (rsp_q.size() != 0) begin errors++; $display("FAIL reset_no_rsp: got %0d responses want 0", rsp_q.size()); end
    checks++; if (data_out !== '0)   begin errors++; $display("FAIL reset_data_after: got %h want 0", data_out); end
    checks++; if (wb_ovf !== 1'b0)   begin errors++; $display("FAIL reset_ovf_after: got %b want 0", wb_ovf); end
  endtask

  task automatic test_write_read();
    rsp_q.delete();
    step(1'b1, 18'h10, 32'h1234_5678, 1'b0, '0);
    idle(1);
    step(1'b0, '0, '0, 1'b1, 18'h10);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL wr_rd_lat0: valid got %b want 0", valid); end
    idle(1);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL wr_rd_lat1: valid got %b want 0", valid); end
    idle(1);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL wr_rd_lat2: valid got %b want 1", valid); end
    checks++; if (data_out !== 32'h1234_5678) begin errors++; $display("FAIL wr_rd_data: got %h want 12345678", data_out); end
    idle(1);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL wr_rd_pulse: valid got %b want 0", valid); end
    checks++; if (data_out !== 32'h1234_5678) begin errors++; $display("FAIL wr_rd_hold: got %h want 12345678", data_out); end
  endtask

  task automatic test_same_cycle_fwd();
    logic [DATA_WIDTH-1:0] exp_q [3];
    preload(18'h5, 32'h55);
    preload(18'h6, 32'h66);
    preload(18'h7, 32'h77);
    exp_q[0] = 32'h55;
`ifdef DRAM_RSP_WB_FWD_EN
    exp_q[1] = 32'hDEAD_BEEF;
`else
    exp_q[1] = 32'h66;
`endif
    exp_q[2] = 32'h77;
    rsp_q.delete();
    step(1'b0, '0, '0, 1'b1, 18'h5);
    step(1'b1, 18'h6, 32'hDEAD_BEEF, 1'b1, 18'h6);
    step(1'b0, '0, '0, 1'b1, 18'h7);
    idle(4);
    checks++; if (rsp_q.size() != 3) begin errors++; $display("FAIL fwd_count: got %0d responses want 3", rsp_q.size()); end
    for (int i = 0; i < 3; i++) begin
      logic [DATA_WIDTH-1:0] got;
      got = (i < rsp_q.size()) ? rsp_q[i] : 'x;
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL fwd_rsp%0d: got %h want %h", i, got, exp_q[i]); end
    end
    rsp_q.delete();
    step(1'b0, '0, '0, 1'b1, 18'h6);
    idle(3);
    checks++; if (rsp_q.size() != 1 || rsp_q[0] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL fwd_after_drain: got %0d rsp, first %h want DEADBEEF", rsp_q.size(), (rsp_q.size() > 0) ? rsp_q[0] : 'x);
    end
  endtask

  task automatic test_overflow();
    logic [ADDR_WIDTH-1:0] rd_a [7];
    logic [DATA_WIDTH-1:0] rd_e [7];
    preload(18'h104, 32'hA4);
    rsp_q.delete();
    for (int i = 0; i < 4; i++)
      step(1'b1, ADDR_WIDTH'(32'h100 + i), DATA_WIDTH'(32'hB0 + i), 1'b1, 18'h10);
    checks++; if (wb_ovf !== 1'b0) begin errors++; $display("FAIL ovf_before: got %b want 0", wb_ovf); end
    step(1'b1, 18'h104, 32'hB4, 1'b1, 18'h10);
    checks++; if (wb_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", wb_ovf); end
    idle(4);
    checks++; if (rsp_q.size() != 5) begin errors++; $display("FAIL ovf_rsp_count: got %0d want 5", rsp_q.size()); end
    // Refill, then a write-only cycle on a full buffer must be accepted.
    for (int i = 0; i < 4; i++)
      step(1'b1, ADDR_WIDTH'(32'h108 + i), DATA_WIDTH'(32'hC0 + i), 1'b1, 18'h10);
    step(1'b1, 18'h10C, 32'hCC, 1'b0, '0);
    idle(4);
    checks++; if (wb_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", wb_ovf); end
    rd_a = '{18'h100, 18'h101, 18'h102, 18'h103, 18'h104, 18'h108, 18'h10C};
    rd_e = '{32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hA4, 32'hC0, 32'hCC};
    rsp_q.delete();
    for (int i = 0; i < 7; i++) step(1'b0, '0, '0, 1'b1, rd_a[i]);
    idle(3);
    for (int i = 0; i < 7; i++) begin
      logic [DATA_WIDTH-1:0] got;
      got = (i < rsp_q.size()) ? rsp_q[i] : 'x;
      checks++; if (got !== rd_e[i]) begin errors++; $display("FAIL ovf_read%0d: addr %h got %h want %h", i, rd_a[i], got, rd_e[i]); end
    end
  endtask

  task automatic test_newest_match();
    logic [DATA_WIDTH-1:0] exp_q [4];
    preload(18'h9, 32'h99);
    exp_q[0] = 32'h1234_5678;
    exp_q[1] = 32'h1234_5678;
`ifdef DRAM_RSP_WB_FWD_EN
    exp_q[2] = 32'h2;
`else
    exp_q[2] = 32'h99;
`endif
    exp_q[3] = 32'h1234_5678;
    rsp_q.delete();
    step(1'b1, 18'h9, 32'h1, 1'b1, 18'h10);
    step(1'b1, 18'h9, 32'h2, 1'b1, 18'h10);
    step(1'b0, '0, '0, 1'b1, 18'h9);
    step(1'b0, '0, '0, 1'b1, 18'h10);
    idle(4);
    for (int i = 0; i < 4; i++) begin
      logic [DATA_WIDTH-1:0] got;
      got = (i < rsp_q.size()) ? rsp_q[i] : 'x;
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL newest_rsp%0d: got %h want %h", i, got, exp_q[i]); end
    end
    rsp_q.delete();
    step(1'b0, '0, '0, 1'b1, 18'h9);
    idle(3);
    checks++; if (rsp_q.size() != 1 || rsp_q[0] !== 32'h2) begin
      errors++; $display("FAIL newest_drained: got %0d rsp, first %h want 2", rsp_q.size(), (rsp_q.size() > 0) ? rsp_q[0] : 'x);
    end
  endtask

  task automatic test_mid_reset();
    preload(18'h40, 32'h4000);
    preload(18'h41, 32'h4100);
    rsp_q.delete();
    step(1'b1, 18'h40, 32'h111, 1'b1, 18'h10);
    step(1'b1, 18'h41, 32'h222, 1'b1, 18'h10);
    srstn = 1'b0;
    step(1'b1, 18'h40, 32'h0BAD, 1'b1, 18'h40);
    step(1'b1, 18'h41, 32'h0BAD, 1'b1, 18'h41);
    srstn = 1'b1;
    idle(4);
    checks++; if (rsp_q.size() != 0) begin errors++; $display("FAIL mrst_no_rsp: got %0d responses want 0", rsp_q.size()); end
    checks++; if (data_out !== '0)   begin errors++; $display("FAIL mrst_data: got %h want 0", data_out); end
    checks++; if (wb_ovf !== 1'b0)   begin errors++; $display("FAIL mrst_ovf: got %b want 0", wb_ovf); end
    rsp_q.delete();
    step(1'b0, '0, '0, 1'b1, 18'h40);
    step(1'b0, '0, '0, 1'b1, 18'h41);
    idle(3);
    checks++; if (rsp_q.size() != 2) begin errors++; $display("FAIL mrst_rd_count: got %0d want 2", rsp_q.size()); end
    checks++; if (rsp_q.size() < 1 || rsp_q[0] !== 32'h4000) begin
      errors++; $display("FAIL mrst_rd40: got %h want 4000", (rsp_q.size() > 0) ? rsp_q[0] : 'x);
    end
    checks++; if (rsp_q.size() < 2 || rsp_q[1] !== 32'h4100) begin
      errors++; $display("FAIL mrst_rd41: got %h want 4100", (rsp_q.size() > 1) ? rsp_q[1] : 'x);
    end
  endtask

  initial begin
    srstn   = 1'b0;
    en_wr   = 1'b0;
    addr_wr = '0;
    data_in = '0;
    en_rd   = 1'b0;
    addr_rd = '0;
    test_reset();
    test_write_read();
    test_same_cycle_fwd();
    test_overflow();
    test_newest_match();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
